// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the FP MAC adder path: field positions of an
// IEEE-754 single, internal mantissa width and the alignment FSM states.
package fp_mac_pkg;

  localparam int EW       = 8;
  localparam int MW       = 23;
  localparam int MANT_W   = MW + 1;
  localparam int CNT_W    = 5;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;

  // Shifts of 24 or more push the whole mantissa out of the window.
  localparam logic [EW-1:0] MAX_SHIFT = 8'd24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic hidden_bit(input logic [EW-1:0] exp_field);
    return (exp_field != {EW{1'b0}});
  endfunction

endpackage

// File: rtl/fp_align_if.sv
// Operand/result handshake bundle between the alignment stage, its producer
// and the downstream mantissa adder.
interface fp_align_if;

  logic                           in_valid;
  logic                           in_ready;
  logic [31:0]                    a;
  logic [31:0]                    b;
  logic                           out_valid;
  logic                           out_ready;
  logic [fp_mac_pkg::MANT_W-1:0]  mx;
  logic [fp_mac_pkg::MANT_W-1:0]  my;
  logic [fp_mac_pkg::EW-1:0]      ex;
  logic                           s;
  logic                           s1;
  logic                           s2;
  logic                           s3;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, mx, my, ex, s, s1, s2, s3
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, mx, my, ex, s, s1, s2, s3
  );

endinterface

// File: rtl/fp_unpack.sv
// Splits one IEEE-754 single into sign, raw exponent and hidden-bit mantissa.
// NaN/Inf are not special-cased.
module fp_unpack
  import fp_mac_pkg::*;
(
  input  logic [31:0]       op,
  output logic              sgn,
  output logic [EW-1:0]     exp_f,
  output logic [MANT_W-1:0] mant
);

  assign sgn   = op[SIGN_BIT];
  assign exp_f = op[EXP_HI:EXP_LO];
  assign mant  = {hidden_bit(op[EXP_HI:EXP_LO]), op[FRAC_HI:FRAC_LO]};

endmodule

// File: rtl/fp_align.sv
// Pre-adder alignment: orders two operands by exponent and right-shifts the
// smaller mantissa one bit per cycle until it shares the larger exponent.
module fp_align
  import fp_mac_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  fp_align_if.slave bus
);

  state_t             state_r;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [MANT_W-1:0]  mx_r;
  logic [MANT_W-1:0]  my_r;
  logic [EW-1:0]      ex_r;
  logic               s_r;
  logic               s1_r;
  logic               s2_r;
  logic               s3_r;

  logic               sa_s;
  logic               sb_s;
  logic [EW-1:0]      ea_s;
  logic [EW-1:0]      eb_s;
  logic [MANT_W-1:0]  ma_s;
  logic [MANT_W-1:0]  mb_s;
  logic               no_swap_s;
  logic [EW-1:0]      d_s;

  fp_unpack u_unpack_a (.op(a_r), .sgn(sa_s), .exp_f(ea_s), .mant(ma_s));
  fp_unpack u_unpack_b (.op(b_r), .sgn(sb_s), .exp_f(eb_s), .mant(mb_s));

  // Order operands by exponent; the difference is always taken larger-minus-smaller.
  always_comb begin
    no_swap_s = 1'b0;
    d_s       = {EW{1'b0}};
    if (ea_s >= eb_s) begin
      no_swap_s = 1'b1;
      d_s       = ea_s - eb_s;
    end else begin
      no_swap_s = 1'b0;
      d_s       = eb_s - ea_s;
    end
  end

  // Alignment FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      mx_r        <= {MANT_W{1'b0}};
      my_r        <= {MANT_W{1'b0}};
      ex_r        <= {EW{1'b0}};
      s_r         <= 1'b0;
      s1_r        <= 1'b0;
      s2_r        <= 1'b0;
      s3_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            in_ready_r <= 1'b0;
            state_r    <= CMP;
          end
        end
        CMP: begin
          s_r  <= no_swap_s;
          mx_r <= no_swap_s ? ma_s : mb_s;
          ex_r <= no_swap_s ? ea_s : eb_s;
          s1_r <= sa_s;
          s2_r <= sb_s;
          s3_r <= sa_s ^ sb_s;
          if (d_s >= MAX_SHIFT) begin
            my_r        <= {MANT_W{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (d_s == {EW{1'b0}}) begin
            my_r        <= no_swap_s ? mb_s : ma_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            my_r    <= no_swap_s ? mb_s : ma_s;
            cnt_r   <= d_s[CNT_W-1:0];
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          // Truncating shift: no guard/sticky bits are kept at this stage.
          my_r  <= my_r >> 1;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.mx        = mx_r;
  assign bus.my        = my_r;
  assign bus.ex        = ex_r;
  assign bus.s         = s_r;
  assign bus.s1        = s1_r;
  assign bus.s2        = s2_r;
  assign bus.s3        = s3_r;

endmodule

// File: tb/tb_fp_align.sv
// Directed self-checking bench for fp_align: latency, ordering, shift result,
// sign flags, back-pressure and mid-operation reset.
module tb_fp_align;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_align_if bus ();

  fp_align u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fields(input string tag, input logic [23:0] emx, input logic [23:0] emy,
                            input logic [7:0] eex, input logic es, input logic es1,
                            input logic es2, input logic es3);
    chk({tag, ".mx"}, {8'd0, bus.mx}, {8'd0, emx});
    chk({tag, ".my"}, {8'd0, bus.my}, {8'd0, emy});
    chk({tag, ".ex"}, {24'd0, bus.ex}, {24'd0, eex});
    chk({tag, ".s"},  {31'd0, bus.s},  {31'd0, es});
    chk({tag, ".s1"}, {31'd0, bus.s1}, {31'd0, es1});
    chk({tag, ".s2"}, {31'd0, bus.s2}, {31'd0, es2});
    chk({tag, ".s3"}, {31'd0, bus.s3}, {31'd0, es3});
  endtask

  // One full operation; hold > 0 keeps out_ready low for that many cycles of DONE.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input int lat, input logic [23:0] emx, input logic [23:0] emy,
                        input logic [7:0] eex, input logic es, input logic es1,
                        input logic es2, input logic es3, input int hold);
    int cyc;
    bus.out_ready = (hold == 0);
    chk({tag, ".in_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk({tag, ".in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
    cyc = 1;
    while (!bus.out_valid && cyc < 60) begin
      step();
      cyc++;
    end
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk_fields(tag, emx, emy, eex, es, es1, es2, es3);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, ".hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk_fields({tag, ".hold"}, emx, emy, eex, es, es1, es2, es3);
    end
    bus.out_ready = 1'b1;
    step();
    chk({tag, ".post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".post_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk_fields("rst", 24'h0, 24'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // 1.0 vs 0.5: d=1
    run_op("one_half", 32'h3F800000, 32'h3F000000, 3,
           24'h800000, 24'h400000, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // 0.5 vs 2.0: swapped, d=2
    run_op("swap", 32'h3F000000, 32'h40000000, 4,
           24'h800000, 24'h200000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // d=24 exactly flushes the smaller mantissa
    run_op("d24", 32'h4B800000, 32'h3F800000, 2,
           24'h800000, 24'h000000, 8'h97, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Equal exponents, opposite signs
    run_op("eq_sub", 32'h3F800000, 32'hBF800000, 2,
           24'h800000, 24'h800000, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    // Both zero
    run_op("zeros", 32'h00000000, 32'h00000000, 2,
           24'h000000, 24'h000000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // 3.0 vs -1.25: fraction bits shift with the hidden bit
    run_op("frac", 32'h40400000, 32'hBFA00000, 3,
           24'hC00000, 24'h500000, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    // Denormal B (no hidden bit), truncating shift 3 -> 1
    run_op("denorm", 32'h00800000, 32'h00000003, 3,
           24'h800000, 24'h000001, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Back-pressure: 2.0 vs 1.0 held for 5 cycles
    run_op("backpress", 32'h40000000, 32'h3F800000, 3,
           24'h800000, 24'h400000, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 5);

    // Reset while shifting (d=10)
    bus.out_ready = 1'b1;
    bus.a         = 32'h44800000;
    bus.b         = 32'h3F800000;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("mid.in_shift", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk_fields("mid", 24'h0, 24'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("mid.discarded", {31'd0, bus.out_valid}, 32'd0);
    run_op("after_rst", 32'h44800000, 32'h3F800000, 12,
           24'h800000, 24'h002000, 8'h89, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_align.md
Name: fp_align

Overview:
- Pre-adder alignment stage of the floating-point MAC adder path, sitting upstream of the post-add normaliser.
- Unpacks two IEEE-754 single-precision operands and orders them by exponent.
- Right-shifts the smaller-exponent mantissa one bit per cycle until both mantissas share the larger exponent.
- Hands aligned mantissas, common exponent and sign/control flags (s, s1, s2, s3) to the mantissa adder under a valid/ready handshake.

Parameters:
- EW, 8, exponent field width
- MW, 23, stored fraction width; internal mantissas are MW+1 bits with the hidden bit

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- a  in  32  operand A, IEEE-754 single
- b  in  32  operand B, IEEE-754 single
- out_valid  out  1  aligned result valid
- out_ready  in  1  consumer accepts result
- mx  out  24  mantissa of the larger-exponent operand, hidden bit included
- my  out  24  mantissa of the smaller-exponent operand, right-aligned
- ex  out  8  common (larger) exponent
- s  out  1  1 = no swap (ea >= eb); 0 = swapped
- s1  out  1  sign of A
- s2  out  1  sign of B
- s3  out  1  effective subtraction, s1 ^ s2

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, in_ready=1, mx=0, my=0, ex=0, s=0, s1=0, s2=0, s3=0, state=IDLE, shift counter=0.
- Unpack rules:
  - hidden bit = 1 when the exponent field is nonzero, else 0.
  - Exponent is used raw, with no bias removal.
  - NaN/Inf get no special handling and pass through as ordinary values.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready in cycle T, register a and b, then go to CMP.
  - CMP (T+1):
    - If ea >= eb: s=1, mx=ma, my=mb, ex=ea, d=ea-eb.
    - Else: s=0, mx=mb, my=ma, ex=eb, d=eb-ea.
    - s1, s2, s3 are latched here.
    - If d >= 24: my=0, n=0. Otherwise n=d.
    - If n=0, go to DONE; else load the counter with n and go to SHIFT.
  - SHIFT: each cycle my = my >> 1 (logical, truncating, no guard or sticky bits) and the counter decrements. Leave for DONE when the counter reaches 1.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0. On out_valid&out_ready, go to IDLE. in_ready rises the following cycle.
- Latency: out_valid first asserts in cycle T+2+n, where n=min(d,24) if d<24 and n=0 if d>=24.
- Throughput: one operation in flight.
- Timing rules:
  - in_ready=0 in CMP, SHIFT and DONE.
  - No same-cycle accept in DONE.
- Boundary conditions:
  - Equal exponents: no swap, s=1.
  - d=24 exactly: my=0.
  - Both operands zero: ex=0, mx=my=0, latency 2.
- Reset mid-operation (any state): the next cycle matches the reset values, and the in-flight operation is discarded.
- Arithmetic: exponent difference is computed 8-bit unsigned after ordering, so there is no wrap-around.

Decomposition:
- Shared package fp_mac_pkg:
  - EW, MW, MANT_W=MW+1
  - state enum {IDLE, CMP, SHIFT, DONE}
  - field-slice constants: sign bit 31, exponent [30:23], fraction [22:0]
- Sub-module fp_unpack: combinational split of one operand into sign, exponent and hidden-bit mantissa. Instantiated twice.

Test Plan:
- A=0x3F800000 (1.0), B=0x3F000000 (0.5), out_ready=1 -> out_valid at T+3; ex=0x7F, mx=0x800000, my=0x400000, s=1, s1=0, s2=0, s3=0.
- A=0x3F000000, B=0x40000000 -> swap, d=2; out_valid at T+4; ex=0x80, mx=0x800000, my=0x200000, s=0.
- A=0x4B800000, B=0x3F800000 (d=24) -> my=0, ex=0x97, mx=0x800000; out_valid at T+2.
- A=0x3F800000, B=0xBF800000 -> d=0; s1=0, s2=1, s3=1, s=1, mx=my=0x800000; out_valid at T+2.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; raise out_ready -> handshake, then in_ready=1 the next cycle.
- Reset during SHIFT with d=10 (A exp 0x89, B exp 0x7F) -> cycle after rst: out_valid=0, in_ready=1, all outputs 0; a new operation afterwards completes normally.
